// File: rtl/scmi_mbox_multi_if.sv
// rtl/scmi_mbox_multi_if.sv - register-bus request/response bundle for the SCMI mailbox
interface scmi_mbox_multi_if #(
    parameter int unsigned AddrWidth = 32
);
    logic                 valid;
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 ready;
    logic [31:0]          rdata;
    logic                 error;

    modport master (
        output valid, write, addr, wdata, wstrb,
        input  ready, rdata, error
    );

    modport slave (
        input  valid, write, addr, wdata, wstrb,
        output ready, rdata, error
    );
endinterface

// File: rtl/scmi_mbox_multi.sv
// rtl/scmi_mbox_multi.sv - multi-channel SCMI shared-memory mailbox with doorbell/completion FSMs
// Optional: define SCMI_MBOX_ERR_RESP_EN to also flag protocol violations on the bus error signal.
module scmi_mbox_multi #(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned PayloadWords = 8,
    parameter int unsigned AddrWidth    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    scmi_mbox_multi_if.slave       reg_bus,
    output logic [NumChannels-1:0] irq_agent_o,
    output logic [NumChannels-1:0] irq_host_o
);

    localparam int unsigned ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned PwW = (PayloadWords > 1) ? $clog2(PayloadWords) : 1;
    localparam logic [4:0]  ChanCount  = 5'(NumChannels);
    localparam logic [6:0]  PayloadEnd = 7'(8 + PayloadWords);

    localparam logic [5:0] OffStatus     = 6'd0;
    localparam logic [5:0] OffFlags      = 6'd1;
    localparam logic [5:0] OffLength     = 6'd2;
    localparam logic [5:0] OffDoorbell   = 6'd3;
    localparam logic [5:0] OffCompletion = 6'd4;
    localparam logic [5:0] OffPayload    = 6'd8;

    typedef enum logic {
        CH_FREE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_e;

    ch_state_e                state_q [NumChannels];
    ch_state_e                state_d [NumChannels];
    logic [NumChannels-1:0]   err_q, err_d;
    logic [NumChannels-1:0]   ien_q, ien_d;
    logic [NumChannels-1:0]   db_pend_q, db_pend_d;
    logic [NumChannels-1:0]   cmpl_pend_q, cmpl_pend_d;
    logic [31:0]              length_q  [NumChannels];
    logic [31:0]              payload_q [NumChannels][PayloadWords];

    logic                     ready_q;
    logic [31:0]              rdata_q;
    logic                     error_q;
    logic                     wr_en_q;
    logic [ChW-1:0]           wr_ch_q;
    logic [5:0]               wr_off_q;
    logic [31:0]              wr_data_q;
    logic [3:0]               wr_strb_q;
    logic                     apply;

    logic [3:0]               req_ch_full;
    logic [ChW-1:0]           req_ch;
    logic [5:0]               req_off;
    logic [5:0]               req_pofs;
    logic [PwW-1:0]           req_pidx;
    logic                     req_dec_err;
    logic                     req_viol;
    logic [31:0]              req_rdata;
    logic [5:0]               wr_pofs;
    logic [PwW-1:0]           wr_pidx;

    // Full 4-bit channel field so unpopulated channel windows decode as errors instead of aliasing.
    always_comb begin
        req_ch_full = reg_bus.addr[11:8];
        req_ch      = req_ch_full[ChW-1:0];
        req_off     = reg_bus.addr[7:2];
        req_pofs    = req_off - OffPayload;
        req_pidx    = req_pofs[PwW-1:0];
        req_rdata   = '0;
        req_viol    = 1'b0;
        req_dec_err = ({1'b0, req_ch_full} >= ChanCount);
        if (!req_dec_err) begin
            case (req_off)
                OffStatus:     req_rdata = {30'b0, err_q[req_ch], state_q[req_ch] == CH_FREE};
                OffFlags:      req_rdata = {31'b0, ien_q[req_ch]};
                OffLength:     req_rdata = length_q[req_ch];
                OffDoorbell:   req_rdata = {30'b0, db_pend_q[req_ch], 1'b0};
                OffCompletion: req_rdata = {30'b0, cmpl_pend_q[req_ch], 1'b0};
                default: begin
                    if (req_off >= OffPayload && {1'b0, req_off} < PayloadEnd) begin
                        req_rdata = payload_q[req_ch][req_pidx];
                    end else begin
                        req_dec_err = 1'b1;
                    end
                end
            endcase
        end
        if (!req_dec_err && reg_bus.write && reg_bus.wstrb[0] && reg_bus.wdata[0]) begin
            if (req_off == OffDoorbell && state_q[req_ch] == CH_BUSY) begin
                req_viol = 1'b1;
            end
            if (req_off == OffCompletion && state_q[req_ch] == CH_FREE) begin
                req_viol = 1'b1;
            end
        end
        if (req_dec_err) begin
            req_rdata = '0;
        end
    end

    // Response is registered at accept; the write itself lands at the end of the ready cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_ch_q   <= '0;
            wr_off_q  <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else if (reg_bus.valid && !ready_q) begin
            ready_q   <= 1'b1;
            rdata_q   <= req_rdata;
`ifdef SCMI_MBOX_ERR_RESP_EN
            error_q   <= req_dec_err | req_viol;
`else
            error_q   <= req_dec_err;
`endif
            wr_en_q   <= reg_bus.write && !req_dec_err;
            wr_ch_q   <= req_ch;
            wr_off_q  <= req_off;
            wr_data_q <= reg_bus.wdata;
            wr_strb_q <= reg_bus.wstrb;
        end else begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            wr_en_q   <= 1'b0;
        end
    end

    assign apply   = ready_q && wr_en_q;
    assign wr_pofs = wr_off_q - OffPayload;
    assign wr_pidx = wr_pofs[PwW-1:0];

    // Per-channel FREE/BUSY FSM plus flag next-state; a set beats a simultaneous ack.
    always_comb begin
        for (int c = 0; c < NumChannels; c++) begin
            state_d[c]     = state_q[c];
            err_d[c]       = err_q[c];
            ien_d[c]       = ien_q[c];
            db_pend_d[c]   = db_pend_q[c];
            cmpl_pend_d[c] = cmpl_pend_q[c];
            if (apply && wr_strb_q[0] && wr_ch_q == ChW'(c)) begin
                case (wr_off_q)
                    OffStatus: begin
                        if (wr_data_q[1]) err_d[c] = 1'b0;
                    end
                    OffFlags: begin
                        ien_d[c] = wr_data_q[0];
                    end
                    OffDoorbell: begin
                        if (wr_data_q[1]) db_pend_d[c] = 1'b0;
                        if (wr_data_q[0]) begin
                            if (state_q[c] == CH_BUSY) begin
                                err_d[c] = 1'b1;
                            end else begin
                                state_d[c]   = CH_BUSY;
                                db_pend_d[c] = 1'b1;
                            end
                        end
                    end
                    OffCompletion: begin
                        if (wr_data_q[1]) cmpl_pend_d[c] = 1'b0;
                        if (wr_data_q[0]) begin
                            if (state_q[c] == CH_FREE) begin
                                err_d[c] = 1'b1;
                            end else begin
                                state_d[c] = CH_FREE;
                                if (ien_q[c]) cmpl_pend_d[c] = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChannels; c++) begin
                state_q[c] <= CH_FREE;
            end
            err_q       <= '0;
            ien_q       <= '0;
            db_pend_q   <= '0;
            cmpl_pend_q <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                state_q[c] <= state_d[c];
            end
            err_q       <= err_d;
            ien_q       <= ien_d;
            db_pend_q   <= db_pend_d;
            cmpl_pend_q <= cmpl_pend_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChannels; c++) begin
                length_q[c] <= '0;
                for (int w = 0; w < PayloadWords; w++) begin
                    payload_q[c][w] <= '0;
                end
            end
        end else if (apply) begin
            if (wr_off_q == OffLength && wr_strb_q[0]) begin
                length_q[wr_ch_q] <= wr_data_q;
            end
            if (wr_off_q >= OffPayload) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb_q[b]) begin
                        payload_q[wr_ch_q][wr_pidx][8*b +: 8] <= wr_data_q[8*b +: 8];
                    end
                end
            end
        end
    end

    assign reg_bus.ready = ready_q;
    assign reg_bus.rdata = rdata_q;
    assign reg_bus.error = error_q;
    assign irq_agent_o   = db_pend_q;
    assign irq_host_o    = cmpl_pend_q;

    logic unused_bits;
    assign unused_bits = ^{reg_bus.addr[AddrWidth-1:12], reg_bus.addr[1:0], req_pofs, wr_pofs, req_viol};

endmodule

// File: tb/tb_scmi_mbox_multi.sv
// tb/tb_scmi_mbox_multi.sv - scoreboard bench for the multi-channel SCMI mailbox
module tb_scmi_mbox_multi;

`ifdef SCMI_MBOX_ERR_RESP_EN
    localparam logic ViolErr = 1'b1;
`else
    localparam logic ViolErr = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] irq_agent_o;
    logic [3:0] irq_host_o;

    scmi_mbox_multi_if #(.AddrWidth(32)) bus ();

    scmi_mbox_multi #(
        .NumChannels (4),
        .PayloadWords(8),
        .AddrWidth   (32)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .reg_bus    (bus),
        .irq_agent_o(irq_agent_o),
        .irq_host_o (irq_host_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    exp_t  sb_q[$];
    string sb_name[$];
    int    n_checks = 0;
    int    n_fail = 0;
    logic  ready_prev = 1'b0;

    always @(negedge clk_i) begin
        if (rst_ni && bus.ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: ready=1 with no outstanding access");
            end else begin
                exp_t  e;
                string n;
                e = sb_q.pop_front();
                n = sb_name.pop_front();
                n_checks++;
                if (bus.error !== e.err) begin
                    n_fail++;
                    $display("FAIL %s.error: got %0b expected %0b", n, bus.error, e.err);
                end
                if (e.mask != 32'h0) begin
                    n_checks++;
                    if ((bus.rdata & e.mask) !== e.rdata) begin
                        n_fail++;
                        $display("FAIL %s.rdata: got 0x%08h expected 0x%08h", n, bus.rdata, e.rdata);
                    end
                end
            end
            if (ready_prev) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_pulse: ready held high for two cycles");
            end
        end
        ready_prev = rst_ni && bus.ready;
    end

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] x, input logic [31:0] m,
                          input logic e, input string n);
        int k;
        sb_q.push_back('{rdata: x, mask: m, err: e});
        sb_name.push_back(n);
        @(negedge clk_i);
        bus.valid = 1'b1;
        bus.write = wr;
        bus.addr  = a;
        bus.wdata = d;
        bus.wstrb = s;
        k = 0;
        @(negedge clk_i);
        while (!bus.ready && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        n_checks++;
        if (k != 0) begin
            n_fail++;
            $display("FAIL %s.latency: ready after %0d extra cycles, expected 0", n, k);
        end
        bus.valid = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic e, input string n);
        access(1'b1, a, d, s, 32'h0, 32'h0, e, n);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] x, input logic e, input string n);
        access(1'b0, a, 32'h0, 4'h0, x, 32'hFFFF_FFFF, e, n);
    endtask

    task automatic check_irq(input logic [3:0] ea, input logic [3:0] eh, input string n);
        @(negedge clk_i);
        n_checks++;
        if (irq_agent_o !== ea || irq_host_o !== eh) begin
            n_fail++;
            $display("FAIL %s.irq: agent=%b host=%b expected agent=%b host=%b",
                     n, irq_agent_o, irq_host_o, ea, eh);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid = 1'b0;
        bus.write = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wstrb = '0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (bus.ready !== 1'b0 || bus.rdata !== 32'h0 || bus.error !== 1'b0 ||
            irq_agent_o !== 4'h0 || irq_host_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rdata=0x%08h error=%b agent=%b host=%b expected all 0",
                     bus.ready, bus.rdata, bus.error, irq_agent_o, irq_host_o);
        end
        rst_ni = 1'b1;

        rd(32'h000, 32'h1, 1'b0, "reset_status_ch0");
        check_irq(4'b0000, 4'b0000, "reset_irq");

        wr(32'h204, 32'h1, 4'hF, 1'b0, "ch2_flags");
        wr(32'h20C, 32'h1, 4'hF, 1'b0, "ch2_ring");
        check_irq(4'b0100, 4'b0000, "ch2_ring");
        rd(32'h200, 32'h0, 1'b0, "ch2_status_busy");
        rd(32'h20C, 32'h2, 1'b0, "ch2_db_pend");
        wr(32'h20C, 32'h2, 4'hF, 1'b0, "ch2_agent_ack");
        wr(32'h210, 32'h1, 4'hF, 1'b0, "ch2_complete");
        check_irq(4'b0000, 4'b0100, "ch2_complete");
        rd(32'h200, 32'h1, 1'b0, "ch2_status_free");
        rd(32'h210, 32'h2, 1'b0, "ch2_cmpl_pend");
        wr(32'h210, 32'h2, 4'hF, 1'b0, "ch2_host_ack");
        check_irq(4'b0000, 4'b0000, "ch2_host_ack");

        wr(32'h10C, 32'h1, 4'hF, 1'b0, "ch1_ring");
        wr(32'h10C, 32'h1, 4'hF, ViolErr, "ch1_ring_busy");
        rd(32'h100, 32'h2, 1'b0, "ch1_status_err");
        wr(32'h100, 32'h2, 4'hF, 1'b0, "ch1_err_clear");
        rd(32'h100, 32'h0, 1'b0, "ch1_status_cleared");
        wr(32'h110, 32'h1, 4'hF, 1'b0, "ch1_complete_noien");
        check_irq(4'b0010, 4'b0000, "ch1_complete_noien");
        wr(32'h110, 32'h1, 4'hF, ViolErr, "ch1_complete_free");
        rd(32'h100, 32'h3, 1'b0, "ch1_status_free_err");
        wr(32'h100, 32'h2, 4'hF, 1'b0, "ch1_err_clear2");
        wr(32'h10C, 32'h2, 4'hF, 1'b0, "ch1_agent_ack");
        check_irq(4'b0000, 4'b0000, "ch1_agent_ack");
        wr(32'h10C, 32'h1, 4'b0010, 1'b0, "ch1_ring_nostrb");
        rd(32'h100, 32'h1, 1'b0, "ch1_status_nostrb");
        check_irq(4'b0000, 4'b0000, "ch1_ring_nostrb");

        wr(32'h33C, 32'hDEADBEEF, 4'b0101, 1'b0, "ch3_pay7_wr");
        rd(32'h33C, 32'h00AD00EF, 1'b0, "ch3_pay7_rd");
        wr(32'h320, 32'h12345678, 4'hF, 1'b0, "ch3_pay0_wr");
        rd(32'h320, 32'h12345678, 1'b0, "ch3_pay0_rd");
        wr(32'h308, 32'hA5A50001, 4'hF, 1'b0, "ch3_length_wr");
        rd(32'h308, 32'hA5A50001, 1'b0, "ch3_length_rd");

        rd(32'h500, 32'h0, 1'b1, "dec_channel5_rd");
        wr(32'h50C, 32'h1, 4'hF, 1'b1, "dec_channel5_ring");
        check_irq(4'b0000, 4'b0000, "dec_channel5_ring");
        rd(32'h014, 32'h0, 1'b1, "dec_offset14");
        rd(32'h040, 32'h0, 1'b1, "dec_payload8");
        rd(32'h03C, 32'h0, 1'b0, "ch0_payload7_ok");
        rd(32'h1000, 32'h1, 1'b0, "high_bits_ignored");

        wr(32'h00C, 32'h1, 4'hF, 1'b0, "ch0_ring");
        check_irq(4'b0001, 4'b0000, "ch0_ring");
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (irq_agent_o !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset_irq: agent=%b expected 0000", irq_agent_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        rd(32'h000, 32'h1, 1'b0, "ch0_status_after_reset");
        rd(32'h33C, 32'h0, 1'b0, "ch3_pay7_after_reset");

        repeat (3) @(negedge clk_i);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses missing, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
